longop_seq_ctrl: RTL
====================

LONGOP_SEQ_CTRL -- requirements
Module: longop_seq_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64, meaning the number of BUSY cycles allowed before abort (legal range 2..1024).
REQ-002 Parameter CNT_W, default $clog2(TIMEOUT), meaning the cycle-counter width.
REQ-003 clk  in  1  system clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 instr_valid  in  1  op/func hold a live instruction this cycle.
REQ-006 op  in  6  instruction opcode field.
REQ-007 func  in  6  instruction function field.
REQ-008 divisor_zero  in  1  rt operand equals zero, sampled with instr_valid.
REQ-009 unit_done  in  1  active long-op unit has results ready; one-cycle pulse.
REQ-010 flush  in  1  exception or eret cancels the in-flight long op.
REQ-011 start_div, start_divu, start_mult, start_multu  out  1 each  one-cycle unit start pulses.
REQ-012 stall  out  1  holds the PC and the pipeline (pc_no_add role).
REQ-013 hilo_we  out  1  writes unit results into HI/LO.
REQ-014 kind  out  2  latched op: 00 div, 01 divu, 10 mult, 11 multu.
REQ-015 dz_err  out  1  one-cycle pulse on a divide with zero divisor.
REQ-016 to_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-017 Decode: op=000000 with func 011010/011011/011000/011001 SHALL select div/divu/mult/multu; all other encodings are ignored.
REQ-018 FSM states: IDLE, BUSY, WB.
REQ-019 IDLE, long op valid, not a zero-divisor div/divu, no flush: pulse the matching start_* that cycle, latch kind, clear the counter, go to BUSY next edge.
REQ-020 IDLE, div/divu with divisor_zero=1: no start pulse, dz_err=1 for that cycle, stay in IDLE, no hilo_we.
REQ-021 stall SHALL be 1 in IDLE during a start cycle and throughout BUSY and WB, else 0.
REQ-022 BUSY: counter increments each cycle; unit_done=1 moves to WB next edge.
REQ-023 BUSY: if the counter reaches TIMEOUT-1 with unit_done=0, to_err=1 for that cycle, go to IDLE, no hilo_we.
REQ-024 unit_done and the timeout in the same cycle: unit_done wins, go to WB, no to_err.
REQ-025 WB: hilo_we=1 for exactly one cycle, then go to IDLE.
REQ-026 Latency: start at cycle 0 and done at cycle k give hilo_we at k+1 and stall=0 at k+2.
REQ-027 flush in any state: go to IDLE next edge; suppress start_*, hilo_we and to_err in the flush cycle.
REQ-028 instr_valid in BUSY/WB is ignored; unit_done in IDLE is ignored.
REQ-029 mfhi/mflo/mthi/mtlo never stall in IDLE.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, counter=0, kind=00, and every output to 0, including mid-BUSY.
REQ-031 The first start pulse after release SHALL occur no earlier than the first rising edge with rst=0.

Structure
REQ-032 Shared package: opcode/func constants, kind encoding, FSM state enum.
REQ-033 Single sub-module longop_decode: combinational op/func to {is_long, kind}.

Verification
REQ-034 func=011010, divisor_zero=0, unit_done at cycle 33 -> start_div at 0, hilo_we at 34, stall low at 35, kind=00.
REQ-035 divu with divisor_zero=1 -> dz_err pulse, no start_divu, stall stays 0.
REQ-036 multu with no unit_done, TIMEOUT=8 -> to_err at cycle 7, IDLE at 8, hilo_we never asserted.
REQ-037 mult, flush at cycle 3 -> IDLE at 4, no hilo_we; a new div on cycle 4 starts normally.
REQ-038 rst asserted mid-BUSY -> all outputs 0 asynchronously; a later unit_done causes no hilo_we.

Source files
------------

// File: rtl/longop_seq_ctrl_pkg.sv
// Shared definitions for the long-op sequencer: opcode/func encodings,
// kind encoding of the latched operation, and the FSM state enum.
// Latency: n/a (declarations only). Backpressure: n/a.
package longop_seq_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;

  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;

  typedef enum logic [1:0] {
    KIND_DIV   = 2'b00,
    KIND_DIVU  = 2'b01,
    KIND_MULT  = 2'b10,
    KIND_MULTU = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Divides are the only ops that care about a zero divisor.
  function automatic logic kind_is_div(kind_e k);
    return (k == KIND_DIV) || (k == KIND_DIVU);
  endfunction

endpackage

// File: rtl/longop_seq_ctrl_decode.sv
// Combinational decode of op/func into "is a long op" plus its kind.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: op, func (in, 6 each); is_long (out, 1); kind (out, 2).
module longop_decode
  import longop_seq_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic       is_long,
  output logic [1:0] kind
);

  always_comb begin
    is_long = 1'b0;
    kind    = KIND_DIV;
    if (op == OP_SPECIAL) begin
      case (func)
        FUNC_DIV:   begin is_long = 1'b1; kind = KIND_DIV;   end
        FUNC_DIVU:  begin is_long = 1'b1; kind = KIND_DIVU;  end
        FUNC_MULT:  begin is_long = 1'b1; kind = KIND_MULT;  end
        FUNC_MULTU: begin is_long = 1'b1; kind = KIND_MULTU; end
        default:    begin is_long = 1'b0; kind = KIND_DIV;   end
      endcase
    end
  end

endmodule

// File: rtl/longop_seq_ctrl.sv
// Sequences mult/div long ops: start pulse, stall while busy, HI/LO write-back,
// divide-by-zero and timeout reporting. Latency: done at cycle k -> hilo_we at k+1.
// Backpressure: stall holds the pipeline from the start cycle through write-back.
// Ports: clk, rst (async, active high); instr_valid, op, func, divisor_zero,
//   unit_done, flush (in); start_div/divu/mult/multu, stall, hilo_we, kind,
//   dz_err, to_err (out).
module longop_seq_ctrl
  import longop_seq_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       divisor_zero,
  input  logic       unit_done,
  input  logic       flush,
  output logic       start_div,
  output logic       start_divu,
  output logic       start_mult,
  output logic       start_multu,
  output logic       stall,
  output logic       hilo_we,
  output logic [1:0] kind,
  output logic       dz_err,
  output logic       to_err
);

  // The counter is cleared on the start edge, so in BUSY it trails the
  // cycle-since-start number by one; cycle TIMEOUT-1 therefore sees TIMEOUT-2.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       kind_q, kind_d;

  logic             dec_long;
  logic [1:0]       dec_kind;

  logic [3:0]       start_c;
  logic             stall_c;
  logic             hilo_c;
  logic             dz_c;
  logic             to_c;

  longop_decode u_decode (
    .op      (op),
    .func    (func),
    .is_long (dec_long),
    .kind    (dec_kind)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      kind_q  <= KIND_DIV;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    start_c = 4'b0000;
    stall_c = 1'b0;
    hilo_c  = 1'b0;
    dz_c    = 1'b0;
    to_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A flushed instruction is cancelled outright, including its dz report.
        if (instr_valid && dec_long && !flush) begin
          if (kind_is_div(kind_e'(dec_kind)) && divisor_zero) begin
            dz_c = 1'b1;
          end else begin
            start_c[dec_kind] = 1'b1;
            stall_c           = 1'b1;
            kind_d            = dec_kind;
            cnt_d             = '0;
            state_d           = ST_BUSY;
          end
        end
      end

      ST_BUSY: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        // unit_done outranks the timeout when both land together.
        if (flush) begin
          state_d = ST_IDLE;
        end else if (unit_done) begin
          state_d = ST_WB;
        end else if (cnt_q == CNT_LAST) begin
          to_c    = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_WB: begin
        stall_c = 1'b1;
        hilo_c  = !flush;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Mealy outputs are masked by rst so nothing leaks out while reset is held,
  // even if instr_valid is asserted in the meantime.
  assign start_div   = start_c[KIND_DIV]   & ~rst;
  assign start_divu  = start_c[KIND_DIVU]  & ~rst;
  assign start_mult  = start_c[KIND_MULT]  & ~rst;
  assign start_multu = start_c[KIND_MULTU] & ~rst;
  assign stall       = stall_c & ~rst;
  assign hilo_we     = hilo_c  & ~rst;
  assign dz_err      = dz_c    & ~rst;
  assign to_err      = to_c    & ~rst;
  assign kind        = kind_q;

endmodule
